damage_scheduler: RTL and testbench

Central hit controller for the player. It collects single-cycle `damage` pulses from up to `N_SRC` collision detectors (one per obstacle layer), buffers them, and grants at most one hit per arbitration with a round-robin arbiter. It applies a post-hit immunity window, keeps the player HP count, and flags game over. It sits between the collision detectors and the HP display / game FSM.

---
 rtl/game_pkg.sv | 7 +
 rtl/rr_arbiter.sv | 25 ++
 rtl/damage_scheduler.sv | 82 ++++++++
 tb/tb_damage_scheduler.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// game_pkg: shared encodings and defaults for the player hit path
package game_pkg;
    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_IMMUNE, S_DEAD} state_t;
    localparam int HP_W = 4;
    localparam int HP_MAX_DEF = 5;
    localparam int ONE_SEC_CYCLES = 108000000;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after ptr
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_idx
);
    localparam int IW = $clog2(N);
    int k;
    // Scan farthest-to-nearest so the nearest request after ptr wins
    always_comb begin
        grant_valid = 1'b0;
        grant_idx = '0;
        k = 0;
        for (int i = N; i >= 1; i--) begin
            k = (int'(ptr) + i) % N;
            if (req[k[IW-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx = k[IW-1:0];
            end
        end
    end
endmodule

// File: rtl/damage_scheduler.sv
// damage_scheduler: buffers collision hits, grants one per arbitration, tracks HP and immunity
module damage_scheduler
    import game_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int HP_MAX = HP_MAX_DEF,
    parameter int IMMUNE_CYCLES = ONE_SEC_CYCLES
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     start_in,
    input  logic [N_SRC-1:0]         damage_in,
    output logic [HP_W-1:0]          hp_out,
    output logic                     hit_out,
    output logic [$clog2(N_SRC)-1:0] src_out,
    output logic                     immune_out,
    output logic                     game_over_out
);
    localparam int SW = $clog2(N_SRC);
    localparam int CW = $clog2(IMMUNE_CYCLES);
    state_t state;
    logic [N_SRC-1:0] pending;
    logic [CW-1:0] cnt;
    logic [SW-1:0] ptr;
    logic grant_valid;
    logic [SW-1:0] grant_idx;
    rr_arbiter #(.N(N_SRC)) u_arb (
        .req(pending),
        .ptr(ptr),
        .grant_valid(grant_valid),
        .grant_idx(grant_idx)
    );
    always_ff @(posedge pclk) begin
        hit_out <= 1'b0;
        if (rst) begin
            state <= S_IDLE;
            hp_out <= HP_W'(HP_MAX);
            src_out <= '0;
            immune_out <= 1'b0;
            game_over_out <= 1'b0;
            pending <= '0;
            cnt <= '0;
            ptr <= SW'(N_SRC - 1);
        end else if (start_in) begin
            state <= S_ARMED;
            hp_out <= HP_W'(HP_MAX);
            pending <= '0;
            cnt <= '0;
            immune_out <= 1'b0;
            game_over_out <= 1'b0;
        end else begin
            case (state)
                S_ARMED: begin
                    // Grant cycle discards everything, including same-cycle pulses
                    if (grant_valid) begin
                        ptr <= grant_idx;
                        src_out <= grant_idx;
                        hit_out <= 1'b1;
                        hp_out <= (hp_out == '0) ? '0 : hp_out - 1'b1;
                        pending <= '0;
                        cnt <= '0;
                        state <= (hp_out > HP_W'(1)) ? S_IMMUNE : S_DEAD;
                        immune_out <= hp_out > HP_W'(1);
                        game_over_out <= hp_out <= HP_W'(1);
                    end else begin
                        pending <= pending | damage_in;
                    end
                end
                S_IMMUNE: begin
                    if (cnt == CW'(IMMUNE_CYCLES - 1)) begin
                        cnt <= '0;
                        state <= S_ARMED;
                        immune_out <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_damage_scheduler.sv
// tb_damage_scheduler: directed self-checking bench for damage_scheduler
module tb_damage_scheduler;
    logic pclk = 1'b0;
    logic rst;
    logic start_in;
    logic [3:0] damage_in;
    logic [3:0] hp_out;
    logic hit_out;
    logic [1:0] src_out;
    logic immune_out;
    logic game_over_out;
    int checks = 0;
    int failures = 0;

    damage_scheduler #(.N_SRC(4), .HP_MAX(3), .IMMUNE_CYCLES(8)) dut (
        .pclk(pclk),
        .rst(rst),
        .start_in(start_in),
        .damage_in(damage_in),
        .hp_out(hp_out),
        .hit_out(hit_out),
        .src_out(src_out),
        .immune_out(immune_out),
        .game_over_out(game_over_out)
    );

    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        start_in = 1'b0;
        damage_in = '0;
        tick();
        tick();
        chk("rst_hp", 32'(hp_out), 3);
        chk("rst_hit", 32'(hit_out), 0);
        chk("rst_immune", 32'(immune_out), 0);
        chk("rst_go", 32'(game_over_out), 0);
        chk("rst_src", 32'(src_out), 0);
        rst = 1'b0;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        chk("start_hp", 32'(hp_out), 3);
        chk("start_go", 32'(game_over_out), 0);
        chk("start_immune", 32'(immune_out), 0);

        // single pulse on source 2
        damage_in = 4'b0100;
        tick();
        damage_in = '0;
        chk("p2_nohit_yet", 32'(hit_out), 0);
        tick();
        chk("p2_hit", 32'(hit_out), 1);
        chk("p2_src", 32'(src_out), 2);
        chk("p2_hp", 32'(hp_out), 2);
        chk("p2_immune", 32'(immune_out), 1);
        for (int j = 1; j <= 7; j++) begin
            if (j == 3) damage_in = 4'b0010;
            tick();
            damage_in = '0;
            chk("win_immune", 32'(immune_out), 1);
            chk("win_nohit", 32'(hit_out), 0);
        end
        tick();
        chk("win_end_immune", 32'(immune_out), 0);
        tick();
        tick();
        chk("ignored_pulse_nohit", 32'(hit_out), 0);
        chk("ignored_pulse_hp", 32'(hp_out), 2);

        // source 3 is next after ptr=2; then reset mid-window
        damage_in = 4'b1000;
        tick();
        damage_in = '0;
        tick();
        chk("p3_hit", 32'(hit_out), 1);
        chk("p3_src", 32'(src_out), 3);
        chk("p3_hp", 32'(hp_out), 1);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_hp", 32'(hp_out), 3);
        chk("midrst_immune", 32'(immune_out), 0);
        chk("midrst_hit", 32'(hit_out), 0);
        damage_in = 4'b0001;
        tick();
        damage_in = '0;
        tick();
        chk("idle_nohit", 32'(hit_out), 0);
        tick();
        chk("idle_nohit2", 32'(hit_out), 0);
        chk("idle_hp", 32'(hp_out), 3);

        // held 4'b1111: hits 0,1,2 ten cycles apart, then dead
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        damage_in = 4'b1111;
        for (int h = 0; h < 3; h++) begin
            for (int t = 1; t < ((h == 0) ? 2 : 10); t++) begin
                tick();
                chk("held_gap_nohit", 32'(hit_out), 0);
            end
            tick();
            chk("held_hit", 32'(hit_out), 1);
            chk("held_src", 32'(src_out), 32'(h));
            chk("held_hp", 32'(hp_out), 32'(2 - h));
            chk("held_go", 32'(game_over_out), (h == 2) ? 1 : 0);
            chk("held_immune", 32'(immune_out), (h == 2) ? 0 : 1);
        end
        for (int t = 0; t < 12; t++) begin
            tick();
            chk("dead_nohit", 32'(hit_out), 0);
        end
        chk("dead_go", 32'(game_over_out), 1);
        chk("dead_hp", 32'(hp_out), 0);

        // restart with a simultaneous pulse: start wins, pulse dropped
        damage_in = 4'b0001;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        damage_in = '0;
        chk("restart_hp", 32'(hp_out), 3);
        chk("restart_go", 32'(game_over_out), 0);
        chk("restart_hit", 32'(hit_out), 0);
        tick();
        tick();
        chk("restart_pulse_dropped", 32'(hit_out), 0);
        chk("restart_hp_hold", 32'(hp_out), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
